// File: rtl/sequential_divider_8_bit.sv
// Restoring divider: one quotient bit per clock.
// B==0 short-circuits to DONE with an all-ones quotient.
module sequential_divider_8_bit #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] A,
  input  logic [DIVISOR_W-1:0]  B,
  output logic [DIVIDEND_W-1:0] Q,
  output logic [DIVISOR_W-1:0]  R,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIVISOR_W-1:0]  b_q, b_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W-1:0]  r_q, r_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    rem_sh;
  logic [DIVISOR_W:0]    rem_nx;
  logic                  qbit;
  logic [DIVIDEND_W-1:0] dvd_nx;

  // One restoring step: shift in the dividend MSB, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
    qbit   = 1'b0;
    rem_nx = rem_sh;
    if (rem_sh >= {1'b0, b_q}) begin
      qbit   = 1'b1;
      rem_nx = rem_sh - {1'b0, b_q};
    end
    dvd_nx = {dvd_q[DIVIDEND_W-2:0], qbit};
  end

  // Next-state and register updates for the handshake FSM.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_CALC: begin
        dvd_d = dvd_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DIVIDEND_W - 1)) begin
          q_d     = dvd_nx;
          r_d     = rem_nx[DIVISOR_W-1:0];
          dbz_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: begin
        if (start) begin
          b_d   = B;
          dbz_d = 1'b0;
          if (B == '0) begin
            q_d     = '1;
            r_d     = '0;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            dvd_d   = A;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign busy        = (state_q == S_CALC);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider_8_bit.sv
// Directed bench for sequential_divider_8_bit.
// An arithmetic model is compared against the DUT every cycle.
module tb_sequential_divider_8_bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [3:0] B = '0;
  logic [7:0] Q;
  logic [3:0] R;
  logic       busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  sequential_divider_8_bit #(
    .DIVIDEND_W(8),
    .DIVISOR_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .A(A),
    .B(B),
    .Q(Q),
    .R(R),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles left before the result appears, and visible outputs.
  int m_left = 0;
  bit m_done = 0;
  int m_q = 0, m_r = 0, m_dbz = 0;
  int p_q = 0, p_r = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_done = 0;
      m_q = 0; m_r = 0; m_dbz = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1; m_q = p_q; m_r = p_r; m_dbz = 0;
      end
    end else if (start) begin
      if (B == 0) begin
        m_done = 1; m_q = 255; m_r = 0; m_dbz = 1;
      end else begin
        m_done = 0; m_dbz = 0; m_left = 8;
        p_q = int'(A) / int'(B);
        p_r = int'(A) % int'(B);
      end
    end else begin
      m_done = 0;
    end
  end

  always @(negedge clk) begin
    check("busy", int'(busy), int'(m_left > 0));
    check("done", int'(done), int'(m_done));
    check("Q", int'(Q), m_q);
    check("R", int'(R), m_r);
    check("dbz", int'(div_by_zero), m_dbz);
  end

  task automatic issue(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    start = 1'b1; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout: no done within %0d cycles", cyc);
    end
  endtask

  int tv_a[4] = '{255, 5, 0, 255};
  int tv_b[4] = '{15, 9, 1, 1};
  int tv_q[4] = '{17, 0, 0, 255};
  int tv_r[4] = '{0, 5, 0, 0};

  initial begin
    int cyc;
    int nbusy;
    @(negedge clk);
    check("rst_Q", int'(Q), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // 200 / 7 with busy-length count
    issue(8'd200, 4'd7);
    nbusy = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) nbusy++;
      @(negedge clk);
    end
    check("t1_busy_len", nbusy, 8);
    check("t1_done", int'(done), 1);
    check("t1_Q", int'(Q), 28);
    check("t1_R", int'(R), 4);
    check("t1_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    check("t1_done_pulse", int'(done), 0);

    foreach (tv_a[i]) begin
      issue(8'(tv_a[i]), 4'(tv_b[i]));
      wait_done(cyc);
      check("t2_Q", int'(Q), tv_q[i]);
      check("t2_R", int'(R), tv_r[i]);
    end

    // divide by zero: done right after accept, never busy
    @(negedge clk);
    start = 1'b1; A = 8'd42; B = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check("t3_done", int'(done), 1);
    check("t3_busy", int'(busy), 0);
    check("t3_Q", int'(Q), 255);
    check("t3_R", int'(R), 0);
    check("t3_dbz", int'(div_by_zero), 1);

    // start during CALC is ignored
    issue(8'd100, 4'd3);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; A = 8'd9; B = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("t4_Q", int'(Q), 33);
    check("t4_R", int'(R), 1);

    // async reset mid-CALC
    issue(8'd250, 4'd6);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", int'(busy), 0);
    check("t5_Q", int'(Q), 0);
    check("t5_R", int'(R), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) cyc++;
    end
    check("t5_no_done", cyc, 0);
    issue(8'd17, 4'd4);
    wait_done(cyc);
    check("t5_Q", int'(Q), 4);
    check("t5_R", int'(R), 1);

    // back-to-back accept in the DONE cycle
    start = 1'b1; A = 8'd81; B = 4'd9;
    @(negedge clk);
    start = 1'b0;
    check("t6_busy", int'(busy), 1);
    check("t6_done", int'(done), 0);
    check("t6_Q_hold", int'(Q), 4);
    wait_done(cyc);
    check("t6_Q", int'(Q), 9);
    check("t6_R", int'(R), 0);
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
